// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two queue of fetched {inst, pc} entries with synchronous flush.
// Push and pop may occur together at any occupancy; the caller guarantees no overflow.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head,
    output logic [CNT_W-1:0]   count,
    output logic               empty
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= fetch_entry_t'(push_data);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: PC, synchronous imem requests, 2-entry output queue and redirect handling.
// Optional FETCH_MISALIGN_CHECK_EN flags misaligned redirect targets on misalign_err.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        misalign_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e     state_q;
    fetch_state_e     state_d;
    logic [31:0]      pc_q;
    logic             inflight_q;
    logic             epoch_q;
    logic             resp_epoch_q;
    logic [31:0]      resp_pc_q;
    logic [31:0]      last_pc_q;
    logic             issue;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   pending;
    logic             credit_ok;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;

    assign pop  = ~fifo_empty & dec_ready & ~redirect_valid;
    assign push = inflight_q & (resp_epoch_q == epoch_q) & ~redirect_valid;

    // A same-cycle pop frees its slot for the next issue, which is what keeps one fetch per cycle.
    assign pending   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
    assign credit_ok = pending < (CNT_W + 1)'(FIFO_DEPTH);

    assign push_entry.inst = imem_rdata;
    assign push_entry.pc   = resp_pc_q;

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                issue = ~redirect_valid & credit_ok;
                if (halt && !redirect_valid) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            inflight_q   <= 1'b0;
            epoch_q      <= 1'b0;
            resp_epoch_q <= 1'b0;
            resp_pc_q    <= RESET_PC;
            last_pc_q    <= RESET_PC;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (issue) begin
                resp_pc_q    <= pc_q;
                resp_epoch_q <= epoch_q;
            end
            // The epoch flip orphans any response still on its way back from memory.
            if (redirect_valid) begin
                pc_q    <= {redirect_pc[31:2], 2'b00};
                epoch_q <= ~epoch_q;
            end else if (issue) begin
                pc_q <= pc_q + 32'd4;
            end
            if (pop) begin
                last_pc_q <= head_entry.pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .head     (head_entry),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    assign imem_req  = issue;
    assign imem_addr = pc_q;
    assign dec_valid = ~fifo_empty;
    assign dec_inst  = fifo_empty ? NOP_INST : head_entry.inst;
    assign dec_pc    = fifo_empty ? last_pc_q : head_entry.pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect_valid & (redirect_pc[1:0] != 2'b00);
        end
    end

    assign misalign_err = misalign_q;
`else
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc[1:0];
    assign misalign_err    = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: startup, backpressure, redirect, halt, misalign, PC wrap, reset.
module tb_inst_fetch_unit;

    logic        clk;
    logic        reset;
    logic        dec_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;

    logic        imem_req,  imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic [31:0] imem_rdata, imem_rdata2;
    logic        dec_valid, dec_valid2;
    logic [31:0] dec_inst,  dec_inst2;
    logic [31:0] dec_pc,    dec_pc2;
    logic        misalign_err, misalign_err2;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_mis;

    inst_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_inst      (dec_inst),
        .dec_pc        (dec_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt          (halt),
        .misalign_err  (misalign_err)
    );

    inst_fetch_unit #(
        .RESET_PC(32'hFFFF_FFF8)
    ) dut_wrap (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req2),
        .imem_addr     (imem_addr2),
        .imem_rdata    (imem_rdata2),
        .dec_valid     (dec_valid2),
        .dec_ready     (dec_ready),
        .dec_inst      (dec_inst2),
        .dec_pc        (dec_pc2),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt          (halt),
        .misalign_err  (misalign_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory returning mem[a] = a | 0x13 one cycle after the request.
    always @(posedge clk) begin
        if (imem_req)  imem_rdata  <= imem_addr  | 32'h13;
        if (imem_req2) imem_rdata2 <= imem_addr2 | 32'h13;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic rst, input logic rdy, input logic rv,
                                 input logic [31:0] rpc, input logic hlt);
        @(posedge clk);
        #1;
        reset          = rst;
        dec_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt           = hlt;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %08h expected %08h", tag, observed, expected);
        end
    endtask

    task automatic checkImem(input string tag, input logic req, input logic [31:0] addr);
        checkOutput({tag, ".imem_req"}, {31'b0, imem_req}, {31'b0, req});
        if (req) checkOutput({tag, ".imem_addr"}, imem_addr, addr);
    endtask

    task automatic checkDec(input string tag, input logic vld, input logic [31:0] pc, input logic [31:0] inst);
        checkOutput({tag, ".dec_valid"}, {31'b0, dec_valid}, {31'b0, vld});
        checkOutput({tag, ".dec_pc"}, dec_pc, pc);
        checkOutput({tag, ".dec_inst"}, dec_inst, inst);
    endtask

    initial begin
        reset          = 1'b1;
        dec_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        exp_mis = 32'd1;
`else
        exp_mis = 32'd0;
`endif

        // Reset and startup
        applyStimulus(1, 1, 0, 0, 0);
        checkImem("reset", 0, 0);
        checkOutput("reset.imem_addr", imem_addr, 32'h0);
        checkDec("reset", 0, 32'h0, 32'h13);
        checkOutput("reset.misalign", {31'b0, misalign_err}, 32'd0);
        checkOutput("reset.wrap_addr", imem_addr2, 32'hFFFF_FFF8);
        applyStimulus(0, 1, 0, 0, 0);
        checkImem("boot", 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkImem("c2", 1, 32'h0);
        checkOutput("c2.dec_valid", {31'b0, dec_valid}, 32'd0);
        applyStimulus(0, 1, 0, 0, 0);
        checkImem("c3", 1, 32'h4);
        checkOutput("c3.dec_valid", {31'b0, dec_valid}, 32'd0);
        applyStimulus(0, 1, 0, 0, 0);
        checkImem("c4", 1, 32'h8);
        checkDec("c4", 1, 32'h0, 32'h13);
        applyStimulus(0, 1, 0, 0, 0);
        checkImem("c5", 1, 32'hC);
        checkDec("c5", 1, 32'h4, 32'h17);
        applyStimulus(0, 1, 0, 0, 0);
        checkImem("c6", 1, 32'h10);
        checkDec("c6", 1, 32'h8, 32'h1B);

        // Backpressure: queue fills with 0xC and 0x10, requests stop
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkImem("stall", 0, 0);
            checkDec("stall", 1, 32'hC, 32'h1F);
        end
        applyStimulus(0, 1, 0, 0, 0);
        checkImem("release0", 1, 32'h14);
        checkDec("release0", 1, 32'hC, 32'h1F);
        applyStimulus(0, 1, 0, 0, 0);
        checkImem("release1", 1, 32'h18);
        checkDec("release1", 1, 32'h10, 32'h13);
        applyStimulus(0, 1, 0, 0, 0);
        checkDec("release2", 1, 32'h14, 32'h17);
        applyStimulus(0, 1, 0, 0, 0);
        checkDec("release3", 1, 32'h18, 32'h1B);

        // Redirect with one word queued (0x1C) and one in flight (0x20)
        applyStimulus(0, 1, 1, 32'h100, 0);
        checkImem("redir", 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkImem("redir1", 1, 32'h100);
        checkDec("redir1", 0, 32'h18, 32'h13);
        applyStimulus(0, 1, 0, 0, 0);
        checkImem("redir2", 1, 32'h104);
        checkOutput("redir2.dec_valid", {31'b0, dec_valid}, 32'd0);
        applyStimulus(0, 1, 0, 0, 0);
        checkDec("redir3", 1, 32'h100, 32'h113);
        applyStimulus(0, 1, 0, 0, 0);
        checkDec("redir4", 1, 32'h104, 32'h117);

        // Halt while the queue is full, then drain and resume via redirect
        applyStimulus(0, 0, 0, 0, 1);
        checkImem("halt0", 0, 0);
        checkDec("halt0", 1, 32'h108, 32'h11B);
        applyStimulus(0, 0, 0, 0, 0);
        checkImem("halt1", 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkImem("drain0", 0, 0);
        checkDec("drain0", 1, 32'h108, 32'h11B);
        applyStimulus(0, 1, 0, 0, 0);
        checkImem("drain1", 0, 0);
        checkDec("drain1", 1, 32'h10C, 32'h11F);
        applyStimulus(0, 1, 0, 0, 0);
        checkImem("drain2", 0, 0);
        checkDec("drain2", 0, 32'h10C, 32'h13);
        applyStimulus(0, 1, 1, 32'h40, 0);
        checkImem("resume", 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkImem("resume1", 1, 32'h40);
        checkOutput("resume1.misalign", {31'b0, misalign_err}, 32'd0);
        applyStimulus(0, 1, 0, 0, 0);
        checkImem("resume2", 1, 32'h44);
        applyStimulus(0, 1, 0, 0, 0);
        checkDec("resume3", 1, 32'h40, 32'h53);

        // Misaligned redirect target
        applyStimulus(0, 1, 1, 32'h102, 0);
        checkOutput("mis0.misalign", {31'b0, misalign_err}, 32'd0);
        applyStimulus(0, 1, 0, 0, 0);
        checkImem("mis1", 1, 32'h100);
        checkOutput("mis1.misalign", {31'b0, misalign_err}, exp_mis);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("mis2.misalign", {31'b0, misalign_err}, 32'd0);
        applyStimulus(0, 1, 0, 0, 0);
        checkDec("mis3", 1, 32'h100, 32'h113);

        // Reset mid-stream, asserted together with a misaligned redirect
        applyStimulus(1, 1, 1, 32'h202, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkImem("rst_mid", 0, 0);
        checkOutput("rst_mid.imem_addr", imem_addr, 32'h0);
        checkDec("rst_mid", 0, 32'h0, 32'h13);
        checkOutput("rst_mid.misalign", {31'b0, misalign_err}, 32'd0);
        checkOutput("rst_mid.wrap_pc", dec_pc2, 32'hFFFF_FFF8);
        checkOutput("rst_mid.wrap_req", {31'b0, imem_req2}, 32'd0);

        // PC wrap on the RESET_PC=0xFFFF_FFF8 instance
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("wrap0.req", {31'b0, imem_req2}, 32'd1);
        checkOutput("wrap0.addr", imem_addr2, 32'hFFFF_FFF8);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("wrap1.addr", imem_addr2, 32'hFFFF_FFFC);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("wrap2.addr", imem_addr2, 32'h0);
        checkOutput("wrap2.dec_pc", dec_pc2, 32'hFFFF_FFF8);
        checkOutput("wrap2.dec_inst", dec_inst2, 32'hFFFF_FFFB);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("wrap3.dec_pc", dec_pc2, 32'hFFFF_FFFC);
        checkOutput("wrap3.dec_inst", dec_inst2, 32'hFFFF_FFFF);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("wrap4.dec_valid", {31'b0, dec_valid2}, 32'd1);
        checkOutput("wrap4.dec_pc", dec_pc2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
